// File: rtl/rv_axi_pkg.sv
// rv_axi_pkg: shared arbiter state encoding and AXI channel constants.
package rv_axi_pkg;

  typedef logic [1:0] u2_t;

  typedef enum u2_t {
    Idle = 2'd0,
    Addr = 2'd1,
    Data = 2'd2
  } arbst_t;

  localparam int AXI_AW   = 40;
  localparam int AXI_DW   = 32;
  localparam int AXI_LENW = 8;

endpackage

// File: rtl/rv_axi_rd_arb_if.sv
// rv_axi_rd_arb_if: AXI read address/data channel bundle for N ports.
// The read data and rlast are shared; valid/ready are per port.
interface rv_axi_rd_arb_if
  import rv_axi_pkg::*;
#(
  parameter int N  = 1,
  parameter int AW = AXI_AW,
  parameter int DW = AXI_DW
);

  logic [N-1:0][AW-1:0]       araddr;
  logic [N-1:0][AXI_LENW-1:0] arlen;
  logic [N-1:0]               arvalid;
  logic [N-1:0]               arready;
  logic [DW-1:0]              rd_data;
  logic [N-1:0]               rvalid;
  logic                       rlast;
  logic [N-1:0]               rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rd_data, rvalid, rlast
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rd_data, rvalid, rlast
  );

endinterface

// File: rtl/rv_arb_pick.sv
// rv_arb_pick: combinational 2-way requester pick.
// RV_AXI_RD_ARB_RR_EN selects round-robin tie breaking; otherwise master 0
// has fixed priority.
module rv_arb_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       sel,
  output logic       any
);

  assign any = |req;

`ifdef RV_AXI_RD_ARB_RR_EN
  // On a tie favour the master that did not win last; a lone requester wins.
  assign sel = (&req) ? ~last_gnt : req[1];
`else
  // Master 1 only wins when master 0 is not asking.
  assign sel = ~req[0] & req[1];

  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/rv_axi_rd_arb.sv
// rv_axi_rd_arb: 2:1 AXI read-channel arbiter, one outstanding burst.
// Master 0 is the core port, master 1 the accelerator fetch port. The grant
// is held from address issue until the last data beat. Optional round-robin
// tie breaking via RV_AXI_RD_ARB_RR_EN (see rv_arb_pick).
module rv_axi_rd_arb
  import rv_axi_pkg::*;
#(
  parameter int AW = AXI_AW,
  parameter int DW = AXI_DW
) (
  input  logic           aclk,
  input  logic           arst_n,
  rv_axi_rd_arb_if.slave  m,
  rv_axi_rd_arb_if.master s,
  output logic           gnt,
  output logic           busy,
  output logic           len_err
);

  localparam int CW = AXI_LENW + 1;

  arbst_t                state, state_n;
  logic                  gnt_n;
  logic                  last_gnt, last_gnt_n;
  logic                  len_err_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  pick_sel, pick_any;
  logic [AW-1:0]         araddr_mux;
  logic [AXI_LENW-1:0]   arlen_mux;
  logic [DW-1:0]         rd_data_fwd;
  logic                  ar_hs, r_hs;

  rv_arb_pick u_pick (
    .req      (m.arvalid),
    .last_gnt (last_gnt),
    .sel      (pick_sel),
    .any      (pick_any)
  );

  // Address mux follows gnt; read data and rlast are broadcast unconditionally.
  always_comb begin
    araddr_mux  = m.araddr[gnt];
    arlen_mux   = m.arlen[gnt];
    rd_data_fwd = s.rd_data;
  end

  assign s.araddr[0] = araddr_mux;
  assign s.arlen[0]  = arlen_mux;
  assign m.rd_data   = rd_data_fwd;
  assign m.rlast     = s.rlast;

  // Steer valid/ready so only the granted master talks to the slave.
  always_comb begin
    s.arvalid = '0;
    m.arready = '0;
    s.rready  = '0;
    m.rvalid  = '0;
    case (state)
      Addr: begin
        s.arvalid[0]   = m.arvalid[gnt];
        m.arready[gnt] = s.arready[0];
      end
      Data: begin
        s.rready[0]   = m.rready[gnt];
        m.rvalid[gnt] = s.rvalid[0];
      end
      default: ;
    endcase
  end

  assign ar_hs = s.arvalid[0] & s.arready[0];
  assign r_hs  = s.rvalid[0] & s.rready[0];

  // Next-state: arbitrate in Idle, issue address, count beats until rlast.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    last_gnt_n = last_gnt;
    cnt_n      = cnt;
    len_err_n  = len_err;
    case (state)
      Idle: begin
        if (pick_any) begin
          gnt_n   = pick_sel;
          state_n = Addr;
        end
      end
      Addr: begin
        if (ar_hs) begin
          cnt_n   = {1'b0, arlen_mux} + CW'(1);
          state_n = Data;
        end else if (!m.arvalid[gnt]) begin
          // Requester withdrew before the handshake: abandon without issuing.
          state_n = Idle;
        end
      end
      Data: begin
        if (r_hs) begin
          if (cnt != '0) cnt_n = cnt - CW'(1);
          if (s.rlast) begin
            if (cnt != CW'(1)) len_err_n = 1'b1;
            last_gnt_n = gnt;
            state_n    = Idle;
          end else if (cnt <= CW'(1)) begin
            // Counter exhausted without rlast; keep forwarding until it comes.
            len_err_n = 1'b1;
          end
        end
      end
      default: state_n = Idle;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state    <= Idle;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      cnt      <= '0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      last_gnt <= last_gnt_n;
      cnt      <= cnt_n;
      len_err  <= len_err_n;
    end
  end

  assign busy = (state != Idle);

endmodule
